// File: rtl/decode_stage_if.sv
// Fetch->decode and decode->execute handshake bundle for decode_stage.
// A transfer happens on a rising edge where valid & ready are both high; once raised, valid and its payload hold until that edge.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [4:0]  out_dest;
    logic        out_we;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_op_a, out_op_b, out_imm, out_pc,
               out_opcode, out_funct, out_dest, out_we
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_op_a, out_op_b, out_imm, out_pc,
               out_opcode, out_funct, out_dest, out_we
    );
endinterface

// File: rtl/decode_stage.sv
// Three-phase decode stage: accept (IDLE), register-file read (READ), present to execute (HOLD).
// Operands are bypassed from the write-back port so they always reflect the latest register value.
module decode_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave dif,
    output logic [4:0]    rf_read_addr_a,
    output logic [4:0]    rf_read_addr_b,
    input  logic [31:0]   rf_read_data_a,
    input  logic [31:0]   rf_read_data_b,
    input  logic          wb_enable,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    output logic [1:0]    state_dbg
);
    // IDLE is encoded as 0 so the debug view reads 0 out of reset.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d, pc_q, pc_d;
    logic        pend_a_vld_q, pend_a_vld_d, pend_b_vld_q, pend_b_vld_d;
    logic [31:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic        valid_q, valid_d, we_q, we_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d, out_pc_q, out_pc_d;
    logic [5:0]  opcode_q, opcode_d, funct_q, funct_d;
    logic [4:0]  dest_q, dest_d;

    logic [4:0]  rs, rt, dec_dest;
    logic [5:0]  dec_opcode;
    logic        accept, wb_hit_a, wb_hit_b;

    assign rs         = instr_q[25:21];
    assign rt         = instr_q[20:16];
    assign dec_opcode = instr_q[31:26];
    assign dec_dest   = (dec_opcode == 6'h00) ? instr_q[15:11] : rt;
    assign wb_hit_a   = wb_enable & (wb_addr == rs) & (rs != 5'd0);
    assign wb_hit_b   = wb_enable & (wb_addr == rt) & (rt != 5'd0);

    assign dif.in_ready = (state_q == IDLE) & ~flush & ~rst;
    assign accept       = (state_q == IDLE) & dif.in_valid & dif.in_ready;

    // The register file registers its read, so the address must be steered a cycle ahead.
    always_comb begin
        rf_read_addr_a = rs;
        rf_read_addr_b = rt;
        if (state_q == IDLE) begin
            rf_read_addr_a = dif.in_instr[25:21];
            rf_read_addr_b = dif.in_instr[20:16];
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pend_a_vld_d = pend_a_vld_q;
        pend_b_vld_d = pend_b_vld_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        valid_d      = valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        imm_d        = imm_q;
        out_pc_d     = out_pc_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        dest_d       = dest_q;
        we_d         = we_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = READ;
                    instr_d      = dif.in_instr;
                    pc_d         = dif.in_pc;
                    // A write on the accept edge is missed by the registered read.
                    pend_a_vld_d = wb_enable & (wb_addr == dif.in_instr[25:21]);
                    pend_b_vld_d = wb_enable & (wb_addr == dif.in_instr[20:16]);
                    pend_a_d     = wb_data;
                    pend_b_d     = wb_data;
                end
            end
            READ: begin
                state_d  = HOLD;
                valid_d  = 1'b1;
                op_a_d   = (rs == 5'd0) ? 32'd0 : wb_hit_a ? wb_data :
                           pend_a_vld_q ? pend_a_q : rf_read_data_a;
                op_b_d   = (rt == 5'd0) ? 32'd0 : wb_hit_b ? wb_data :
                           pend_b_vld_q ? pend_b_q : rf_read_data_b;
                opcode_d = dec_opcode;
                funct_d  = instr_q[5:0];
                dest_d   = dec_dest;
                we_d     = !(dec_opcode inside {6'h2B, 6'h04, 6'h05, 6'h02}) && (dec_dest != 5'd0);
                imm_d    = (dec_opcode inside {6'h0C, 6'h0D, 6'h0E}) ?
                           {16'h0000, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};
                out_pc_d = pc_q;
                pend_a_vld_d = 1'b0;
                pend_b_vld_d = 1'b0;
            end
            HOLD: begin
                if (wb_hit_a) op_a_d = wb_data;
                if (wb_hit_b) op_b_d = wb_data;
                if (dif.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            pend_a_vld_d = 1'b0;
            pend_b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            pc_q         <= '0;
            pend_a_vld_q <= 1'b0;
            pend_b_vld_q <= 1'b0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            valid_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            imm_q        <= '0;
            out_pc_q     <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            dest_q       <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pend_a_vld_q <= pend_a_vld_d;
            pend_b_vld_q <= pend_b_vld_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            valid_q      <= valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            imm_q        <= imm_d;
            out_pc_q     <= out_pc_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            dest_q       <= dest_d;
            we_q         <= we_d;
        end
    end

    assign dif.out_valid  = valid_q;
    assign dif.out_op_a   = op_a_q;
    assign dif.out_op_b   = op_b_q;
    assign dif.out_imm    = imm_q;
    assign dif.out_pc     = out_pc_q;
    assign dif.out_opcode = opcode_q;
    assign dif.out_funct  = funct_q;
    assign dif.out_dest   = dest_q;
    assign dif.out_we     = we_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, scored against a register-value model.
module tb_decode_stage;
    localparam int EXP_W = 92;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  rf_read_addr_a, rf_read_addr_b;
    logic [31:0] rf_read_data_a, rf_read_data_b;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  state_dbg;

    decode_stage_if dif();

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .dif(dif),
        .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file with registered read; also the architectural state the model reads
    logic [31:0] regs [32];
    always @(posedge clk) begin
        rf_read_data_a <= regs[rf_read_addr_a];
        rf_read_data_b <= regs[rf_read_addr_b];
        if (wb_enable) regs[wb_addr] <= wb_data;
    end

    // scoreboard: record = {pc, imm, opcode, funct, dest, we, rs, rt}
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] cur;
    logic             m_busy, m_valid;
    int               n_cmp, n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] model_decode(input logic [31:0] instr, input logic [31:0] pc);
        logic [5:0]  opc;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        we;
        opc  = instr[31:26];
        dest = (opc == 6'h00) ? instr[15:11] : instr[20:16];
        if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) imm = 32'(instr[15:0]);
        else imm = 32'($signed(instr[15:0]));
        we = !(opc == 6'h2B || opc == 6'h04 || opc == 6'h05 || opc == 6'h02) && (dest != 5'd0);
        return {pc, imm, opc, instr[5:0], dest, we, instr[25:21], instr[20:16]};
    endfunction

    // one clock: advance the model with the inputs that were applied at this edge, then score
    task automatic cycle();
        logic [31:0] ea, eb;
        @(posedge clk);
        #1;
        if (rst || flush) begin
            m_busy = 1'b0; m_valid = 1'b0; exp_q.delete();
        end else if (!m_busy) begin
            if (dif.in_valid) begin
                m_busy = 1'b1;
                exp_q.push_back(model_decode(dif.in_instr, dif.in_pc));
            end
        end else if (!m_valid) begin
            m_valid = 1'b1;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
        end else if (dif.out_ready) begin
            m_busy = 1'b0; m_valid = 1'b0;
        end
        check_eq("out_valid", 32'(dif.out_valid), 32'(m_valid));
        check_eq("in_ready", 32'(dif.in_ready), 32'(!m_busy && !flush && !rst));
        if (m_valid) begin
            ea = (cur[9:5] == 5'd0) ? 32'd0 : regs[cur[9:5]];
            eb = (cur[4:0] == 5'd0) ? 32'd0 : regs[cur[4:0]];
            check_eq("out_pc", dif.out_pc, cur[91:60]);
            check_eq("out_imm", dif.out_imm, cur[59:28]);
            check_eq("out_opcode", 32'(dif.out_opcode), 32'(cur[27:22]));
            check_eq("out_funct", 32'(dif.out_funct), 32'(cur[21:16]));
            check_eq("out_dest", 32'(dif.out_dest), 32'(cur[15:11]));
            check_eq("out_we", 32'(dif.out_we), 32'(cur[10]));
            check_eq("out_op_a", dif.out_op_a, ea);
            check_eq("out_op_b", dif.out_op_b, eb);
        end
    endtask

    // driver tasks
    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        dif.in_valid = 1'b0;
        wb_enable = 1'b1; wb_addr = a; wb_data = d;
        cycle();
        wb_enable = 1'b0;
    endtask

    task automatic accept(input logic [31:0] instr, input logic [31:0] pc);
        dif.in_instr = instr; dif.in_pc = pc; dif.in_valid = 1'b1;
        cycle();
        dif.in_valid = 1'b0;
    endtask

    task automatic release_out();
        dif.out_ready = 1'b1;
        cycle();
        dif.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; dif.in_valid = 1'b0; dif.out_ready = 1'b0; wb_enable = 1'b0;
        #1;
        m_busy = 1'b0; m_valid = 1'b0; exp_q.delete();
        check_eq("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(dif.in_ready), 32'd0);
        check_eq("rst_op_a", dif.out_op_a, 32'd0);
        check_eq("rst_op_b", dif.out_op_b, 32'd0);
        check_eq("rst_imm", dif.out_imm, 32'd0);
        check_eq("rst_pc", dif.out_pc, 32'd0);
        check_eq("rst_opcode", 32'(dif.out_opcode), 32'd0);
        check_eq("rst_funct", 32'(dif.out_funct), 32'd0);
        check_eq("rst_dest", 32'(dif.out_dest), 32'd0);
        check_eq("rst_we", 32'(dif.out_we), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        cycle();
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(dif.in_ready), 32'd1);
    endtask

    function automatic logic [5:0] pick_opc(input int k);
        case (k)
            0, 1:    return 6'h00;
            2:       return 6'h08;
            3:       return 6'h0C;
            4:       return 6'h0D;
            5:       return 6'h0E;
            6:       return 6'h2B;
            7:       return 6'h04;
            8:       return 6'h05;
            9:       return 6'h02;
            default: return 6'h23;
        endcase
    endfunction

    task automatic rand_drive();
        dif.in_valid  = ($urandom_range(0, 9) < 7);
        dif.in_instr  = {pick_opc($urandom_range(0, 10)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
        dif.in_pc     = $urandom;
        dif.out_ready = 1'($urandom_range(0, 1));
        flush         = ($urandom_range(0, 15) == 0);
        wb_enable     = 1'($urandom_range(0, 1));
        wb_addr       = 5'($urandom_range(0, 7));
        wb_data       = $urandom;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; flush = 1'b0;
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        dif.in_valid = 1'b0; dif.in_instr = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
        m_busy = 1'b0; m_valid = 1'b0; cur = '0;
        #2;
        do_reset();

        for (int i = 0; i < 32; i++) wb_write(5'(i), $urandom);
        wb_write(5'd3, 32'd5);
        wb_write(5'd4, 32'd7);

        // add r4 = r3 + r4
        accept(32'h00642020, 32'h100);
        cycle();
        check_eq("t_add_valid", 32'(dif.out_valid), 32'd1);
        check_eq("t_add_op_a", dif.out_op_a, 32'd5);
        check_eq("t_add_op_b", dif.out_op_b, 32'd7);
        check_eq("t_add_dest", 32'(dif.out_dest), 32'd4);
        check_eq("t_add_we", 32'(dif.out_we), 32'd1);
        release_out();

        // bypass from a write on the accept edge
        dif.in_instr = 32'h00642020; dif.in_pc = 32'h104; dif.in_valid = 1'b1;
        wb_enable = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        cycle();
        dif.in_valid = 1'b0; wb_enable = 1'b0;
        cycle();
        check_eq("t_byp_accept_op_a", dif.out_op_a, 32'h11);
        release_out();

        // bypass from a write during the read cycle
        wb_write(5'd3, 32'd5);
        accept(32'h00642020, 32'h108);
        wb_enable = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        cycle();
        wb_enable = 1'b0;
        check_eq("t_byp_read_op_a", dif.out_op_a, 32'h11);
        release_out();

        // r0 reads as zero
        wb_write(5'd0, 32'hFFFF);
        accept(32'h00042020, 32'h10C);
        wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        cycle();
        wb_enable = 1'b0;
        check_eq("t_r0_op_a", dif.out_op_a, 32'd0);
        release_out();

        // immediate extension and store write-enable
        accept(32'h20648000, 32'h110);
        cycle();
        check_eq("t_imm_sext", dif.out_imm, 32'hFFFF8000);
        release_out();
        accept(32'h34648000, 32'h114);
        cycle();
        check_eq("t_imm_zext", dif.out_imm, 32'h00008000);
        release_out();
        accept(32'hAC648000, 32'h118);
        cycle();
        check_eq("t_store_we", 32'(dif.out_we), 32'd0);
        release_out();

        // stall in HOLD with an rt write, then flush
        accept(32'h00642020, 32'h11C);
        cycle();
        for (int i = 0; i < 5; i++) begin
            wb_enable = (i == 2); wb_addr = 5'd4; wb_data = 32'h99;
            cycle();
        end
        wb_enable = 1'b0;
        check_eq("t_hold_op_b", dif.out_op_b, 32'h99);
        check_eq("t_hold_pc", dif.out_pc, 32'h11C);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check_eq("t_flush_valid", 32'(dif.out_valid), 32'd0);
        check_eq("t_flush_in_ready", 32'(dif.in_ready), 32'd1);

        // reset while in READ discards the instruction
        accept(32'h00642020, 32'h200);
        do_reset();
        cycle();
        cycle();
        accept(32'h00853020, 32'h204);
        cycle();
        check_eq("t_after_rst_dest", 32'(dif.out_dest), 32'd6);
        check_eq("t_after_rst_pc", dif.out_pc, 32'h204);
        release_out();

        for (int i = 0; i < 600; i++) begin
            rand_drive();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
